// File: rtl/four_way_dispatch_pkg.sv
// Lane select encodings and widths shared by the dispatcher and its lanes.
// The optional DISPATCH_STATS_EN build uses STAT_W for its counters.
package dispatch_defs;
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;
  localparam int STAT_W = 16;
  localparam int LANES = 4;
endpackage

// File: rtl/four_way_dispatch_lane.sv
// One-entry lane buffer with valid/ready handshake.
// A load in the same cycle as a drain replaces the word without a bubble.
module dispatch_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         ready_in,
  output logic         valid_out,
  output logic [W-1:0] data_out,
  output logic         can_load
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign can_load  = ~valid_q | ready_in;
  assign valid_out = valid_q;
  assign data_out  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/four_way_dispatch.sv
// 1:4 dispatcher routing one stream to four one-entry lanes by in_sel.
// Per-lane saturating accept counters exist only with DISPATCH_STATS_EN.
module four_way_dispatch
  import dispatch_defs::*;
#(
  parameter int word_size = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [word_size-1:0]   in_data,
  input  logic [1:0]             in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*word_size-1:0] out_data,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [63:0]            stat_count
);
  logic [3:0] can_load;
  logic [3:0] dec;
  logic [3:0] load;
  logic       accept;

  always_comb begin
    dec = 4'b0000;
    unique case (in_sel)
      SEL_A: dec = 4'b0001;
      SEL_B: dec = 4'b0010;
      SEL_C: dec = 4'b0100;
      SEL_D: dec = 4'b1000;
    endcase
  end

  // Readiness looks only at the selected lane, so busy lanes never stall others.
  assign in_ready = can_load[in_sel];
  assign accept   = in_valid & in_ready & ~flush;
  assign load     = accept ? dec : 4'b0000;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dispatch_lane #(
      .W(word_size)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (load[k]),
      .data_in  (in_data),
      .ready_in (out_ready[k]),
      .valid_out(out_valid[k]),
      .data_out (out_data[k*word_size +: word_size]),
      .can_load (can_load[k])
    );
  end

`ifdef DISPATCH_STATS_EN
  logic [LANES*STAT_W-1:0] stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (load[i] && (stat_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}))
          stat_q[i*STAT_W +: STAT_W] <= stat_q[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif
endmodule

// File: tb/tb_four_way_dispatch.sv
// Self-checking bench for four_way_dispatch: vector table, random traffic
// against a lane-occupancy model, async reset and counter saturation.
module tb_four_way_dispatch;
  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [63:0]  stat_count;

  int nerr = 0;
  int nchk = 0;

  bit          mfull[4];
  logic [31:0] mword[4];
  int          mcnt[4];

  always #5 clk = ~clk;

  four_way_dispatch #(.word_size(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stat_count(stat_count)
  );

  typedef struct {
    logic        f;
    logic        v;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  r;
    logic        erdy;
    logic [3:0]  ev;
    logic        cd;
    int          cl;
    logic [31:0] cw;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      mfull[k] = 0;
      mword[k] = '0;
      mcnt[k]  = 0;
    end
  endfunction

  function automatic logic model_rdy(input logic [1:0] s, input logic [3:0] r);
    return !mfull[s] || r[s];
  endfunction

  // A lane is a depth-1 FIFO: pop on drain, push on accept, flush empties it.
  function automatic void model_clock(input logic f, input logic v,
                                      input logic [1:0] s, input logic [31:0] d,
                                      input logic [3:0] r);
    logic acc;
    acc = v && model_rdy(s, r) && !f;
    for (int k = 0; k < 4; k++) begin
      if (mfull[k] && r[k]) mfull[k] = 0;
      if (f) mfull[k] = 0;
    end
    if (acc) begin
      mfull[s] = 1;
      mword[s] = d;
      if (mcnt[s] < 65535) mcnt[s]++;
    end
  endfunction

  function automatic logic [63:0] model_stat();
    logic [63:0] r;
    r = '0;
`ifdef DISPATCH_STATS_EN
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(mcnt[k]);
`endif
    return r;
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mfull[k];
    return v;
  endfunction

  task automatic drive(input logic f, input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] r);
    flush = f;
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = r;
  endtask

  task automatic rand_cycle(inout logic hold);
    logic f, v, e;
    logic [1:0] s;
    logic [31:0] d;
    logic [3:0] r;
    f = ($urandom_range(15) == 0);
    r = 4'($urandom);
    if (hold) begin
      v = 1'b1;
      s = in_sel;
      d = in_data;
    end else begin
      v = ($urandom_range(3) != 0);
      s = 2'($urandom);
      d = $urandom;
    end
    drive(f, v, s, d, r);
    #1;
    e = model_rdy(s, r);
    chk("in_ready", 64'(in_ready), 64'(e));
    hold = v && !e;
    @(posedge clk);
    model_clock(f, v, s, d, r);
    #1;
    chk("out_valid", 64'(out_valid), 64'(model_valid()));
    for (int k = 0; k < 4; k++)
      if (mfull[k]) chk("lane_data", 64'(out_data[k*32 +: 32]), 64'(mword[k]));
    chk("stat_count", stat_count, model_stat());
  endtask

  initial begin
    logic hold;
    logic [63:0] exp_tbl_stat;
    vec_t t;

    tbl[0]  = '{1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 1'b1, 2'd1, 32'h11111111, 4'b0000, 1'b1, 4'b0110, 1'b1, 1, 32'h11111111};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 32'h22222222, 4'b0000, 1'b0, 4'b0110, 1'b1, 1, 32'h11111111};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 32'h22222222, 4'b0010, 1'b1, 4'b0110, 1'b1, 1, 32'h22222222};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 32'h000000A0, 4'b0000, 1'b1, 4'b0111, 1'b1, 0, 32'h000000A0};
    tbl[5]  = '{1'b0, 1'b1, 2'd3, 32'h000000D0, 4'b0000, 1'b1, 4'b1111, 1'b1, 3, 32'h000000D0};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 32'h0BADF00D, 4'b0000, 1'b0, 4'b1111, 1'b1, 0, 32'h000000A0};
    tbl[7]  = '{1'b1, 1'b1, 2'd0, 32'h00000099, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 2'd3, 32'h00000005, 4'b1000, 1'b1, 4'b1000, 1'b1, 3, 32'h00000005};
    tbl[10] = '{1'b0, 1'b0, 2'd3, 32'h00000000, 4'b1000, 1'b1, 4'b0000, 1'b0, 0, 32'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
    model_reset();
    #2;
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_data_lo", out_data[63:0], 64'h0);
    chk("reset_data_hi", out_data[127:64], 64'h0);
    chk("reset_stat", stat_count, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      t = tbl[i];
      drive(t.f, t.v, t.s, t.d, t.r);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(t.erdy));
      @(posedge clk);
      model_clock(t.f, t.v, t.s, t.d, t.r);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(t.ev));
      if (t.cd)
        chk($sformatf("vec%0d_lane_data", i), 64'(out_data[t.cl*32 +: 32]), 64'(t.cw));
    end
`ifdef DISPATCH_STATS_EN
    exp_tbl_stat = 64'h0002_0001_0002_0001;
`else
    exp_tbl_stat = 64'h0;
`endif
    chk("table_stat", stat_count, exp_tbl_stat);

    hold = 1'b0;
    for (int i = 0; i < 500; i++) rand_cycle(hold);

    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 2'(k), 32'hC0DE0000 | k, 4'b0000);
      @(posedge clk);
      model_clock(1'b0, 1'b1, 2'(k), 32'hC0DE0000 | k, 4'b0000);
      #1;
    end
    chk("full_before_reset", 64'(out_valid), 64'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'h0);
    chk("async_reset_data_lo", out_data[63:0], 64'h0);
    chk("async_reset_data_hi", out_data[127:64], 64'h0);
    chk("async_reset_stat", stat_count, 64'h0);
    model_reset();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) rand_cycle(hold);

`ifdef DISPATCH_STATS_EN
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 2'd1, 32'h5A5A5A5A, 4'b0010);
    repeat (70000) @(posedge clk);
    #1;
    chk("stat_saturate", stat_count, 64'h0000_0000_FFFF_0000);
    chk("stat_lane_b_valid", 64'(out_valid), 64'h2);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
